// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, raster total helper and scan-out FSM states.
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int total4(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = total4(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = total4(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster h/v counters with wrap, active-area and sync decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             run,
    input  logic             clr,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_end
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(total4(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(total4(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic h_wrap, v_wrap;

    assign h_wrap    = h_cnt == H_LAST;
    assign v_wrap    = v_cnt == V_LAST;
    assign frame_end = h_wrap && v_wrap;
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync     = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
    assign vsync     = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);

    always_ff @(posedge clk) begin
        if (!rst_ || clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: drains the pixel FIFO into a registered VGA output with sync/DE generation.
// Optional VGA_SCANOUT_UNDERFLOW_CNT_EN adds a saturating per-frame underflow counter.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 12,
    parameter int                    H_ACTIVE        = VGA_H_ACTIVE,
    parameter int                    H_FP            = VGA_H_FP,
    parameter int                    H_SYNC          = VGA_H_SYNC,
    parameter int                    H_BP            = VGA_H_BP,
    parameter int                    V_ACTIVE        = VGA_V_ACTIVE,
    parameter int                    V_FP            = VGA_V_FP,
    parameter int                    V_SYNC          = VGA_V_SYNC,
    parameter int                    V_BP            = VGA_V_BP,
    parameter int                    CNT_W           = 10,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 12'hF0F
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_rts,
    output logic                  in_rtr,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  de,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  frame_start,
    output logic                  underflow
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]           underflow_cnt
`endif
);
    state_t           state;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             run, active, hsync, vsync, frame_end, origin;

    assign run    = state != IDLE;
    assign in_rtr = run && active;
    assign origin = (h_cnt == '0) && (v_cnt == '0);

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) u_timing (
        .clk(clk),
        .rst_(rst_),
        .run(run),
        .clr(state == IDLE),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .active(active),
        .hsync(hsync),
        .vsync(vsync),
        .frame_end(frame_end)
    );

    // DRAIN keeps scanning until the raster's last pixel so a frame is never cut short
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state       <= IDLE;
            rgb         <= '0;
            de          <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state <= state == IDLE ? ((en && in_rts) ? RUN : IDLE)
                   : en ? RUN
                   : (state == DRAIN && frame_end) ? IDLE : DRAIN;
            rgb         <= (run && active) ? (in_rts ? in_data : UNDERFLOW_COLOR) : '0;
            de          <= run && active;
            hsync_n     <= !(run && hsync);
            vsync_n     <= !(run && vsync);
            frame_start <= run && origin;
            underflow   <= run && active && !in_rts;
        end
    end

`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_)
            underflow_cnt <= '0;
        else if (frame_start)
            underflow_cnt <= {15'd0, underflow};
        else if (underflow && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of vga_scanout on a reduced 25x11 raster with a model FIFO.
module tb_vga_scanout;
    typedef struct {
        int         t;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b0;
    logic        in_rts = 1'b0;
    logic [11:0] in_data;
    logic        in_rtr, de, hsync_n, vsync_n, frame_start, underflow;
    logic [11:0] rgb;
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif
    logic [11:0] fifo_data = 12'd0;
    int          pops = 0;
    int          errors = 0;
    int          checks = 0;
    int          done = 0;
    vec_t        tbl[16];
    int          falls[$];

    always #5 clk = ~clk;

    vga_scanout #(
        .DATA_WIDTH(12),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CNT_W(10)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .en(en),
        .in_data(in_data),
        .in_rts(in_rts),
        .in_rtr(in_rtr),
        .rgb(rgb),
        .de(de),
        .hsync_n(hsync_n),
        .vsync_n(vsync_n),
        .frame_start(frame_start),
        .underflow(underflow)
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt(underflow_cnt)
`endif
    );

    // always-full FIFO model delivering an incrementing word per pop
    assign in_data = fifo_data;
    always @(posedge clk) begin
        if (!rst_) begin
            fifo_data <= 12'd0;
            pops      <= 0;
        end else if (in_rts && in_rtr) begin
            fifo_data <= fifo_data + 12'd1;
            pops      <= pops + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, done);
        end
    endtask

    task automatic outs(input string name, input logic e_de, input logic e_hs, input logic e_vs,
                        input logic e_fs, input logic e_uf, input logic [11:0] e_rgb);
        chk(name, {15'd0, de, hsync_n, vsync_n, frame_start, underflow, rgb},
                  {15'd0, e_de, e_hs, e_vs, e_fs, e_uf, e_rgb});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        done++;
    endtask

    task automatic adv(input int n);
        while (done < n) step();
    endtask

    // after this, counters sit at (0,0) in RUN and done counts edges since RUN entry
    task automatic start_run();
        rst_ = 1'b0; en = 1'b0; in_rts = 1'b0;
        step();
        rst_ = 1'b1; en = 1'b1; in_rts = 1'b1;
        step();
        done = 0;
    endtask

    initial begin
        int bad;
        logic prev;
        tbl[0]  = '{0,   1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[1]  = '{15,  1'b1, 1'b1, 1'b1, 1'b0, 12'h00F};
        tbl[2]  = '{16,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[3]  = '{17,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[4]  = '{18,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[5]  = '{21,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[6]  = '{22,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[7]  = '{25,  1'b1, 1'b1, 1'b1, 1'b0, 12'h010};
        tbl[8]  = '{140, 1'b1, 1'b1, 1'b1, 1'b0, 12'h05F};
        tbl[9]  = '{150, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[10] = '{174, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[11] = '{175, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[12] = '{193, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[13] = '{224, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[14] = '{225, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[15] = '{274, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};

        repeat (2) @(negedge clk);
        outs("reset_outs", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        chk("reset_rtr", in_rtr, 0);
        rst_ = 1'b1; en = 1'b1; in_rts = 1'b0;
        repeat (4) step();
        chk("idle_without_rts", {de, in_rtr}, 0);

        // full-FIFO frame walked through the checkpoint table
        start_run();
        chk("rtr_first_run_cycle", in_rtr, 1);
        for (int i = 0; i < 16; i++) begin
            adv(tbl[i].t + 1);
            outs($sformatf("tbl%0d_t%0d", i, tbl[i].t), tbl[i].de, tbl[i].hs, tbl[i].vs,
                 tbl[i].fs, 1'b0, tbl[i].rgb);
        end
        adv(275);
        chk("pops_per_frame", pops, 96);
        adv(276);
        outs("frame2_start", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h060);

        // underflow on pixels (10,0)..(12,0)
        start_run();
        adv(10);
        in_rts = 1'b0;
        chk("uf_rtr_ignores_rts", in_rtr, 1);
        chk("uf_pops_before", pops, 10);
        for (int k = 11; k <= 13; k++) begin
            adv(k);
            outs($sformatf("uf_px%0d", k - 1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'hF0F);
        end
        in_rts = 1'b1;
        chk("uf_no_pops", pops, 10);
        adv(14);
        outs("uf_shifted_data", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h00A);
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
        chk("uf_count", underflow_cnt, 3);
`endif

        // drop en on line 3: frame completes, then IDLE
        start_run();
        adv(75);
        en = 1'b0;
        adv(141);
        outs("drain_active", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h05F);
        adv(270);
        outs("drain_last_line", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        adv(276);
        outs("idle_after_frame", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        chk("idle_rtr", in_rtr, 0);
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (in_rtr || de || !hsync_n || !vsync_n) bad++;
        end
        chk("idle_stays_quiet", bad, 0);

        // en drops and returns within DRAIN: hsync period unbroken
        start_run();
        prev = 1'b1;
        falls.delete();
        for (int d = 1; d <= 120; d++) begin
            if (d == 31) en = 1'b0;
            if (d == 41) en = 1'b1;
            step();
            if (prev && !hsync_n) falls.push_back(done);
            prev = hsync_n;
        end
        chk("hs_fall_count", falls.size(), 5);
        if (falls.size() > 0) chk("hs_first_fall", falls[0], 19);
        for (int k = 1; k < falls.size(); k++)
            chk($sformatf("hs_period%0d", k), falls[k] - falls[k-1], 25);

        // reset pulse mid-frame at pixel (5,3)
        start_run();
        adv(80);
        rst_ = 1'b0;
        step();
        outs("rst_mid_outs", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        chk("rst_mid_rtr", in_rtr, 0);
`ifdef VGA_SCANOUT_UNDERFLOW_CNT_EN
        chk("rst_mid_uf_count", underflow_cnt, 0);
`endif
        rst_ = 1'b1;
        step();
        chk("rst_resume_rtr", in_rtr, 1);
        outs("rst_resume_idle_outs", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        step();
        outs("rst_resume_px0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
